// File: rtl/vga_sync_decoder_if.sv
// Sync inputs and recovered-timing outputs of the VGA sync decoder.
// The sync source drives through master; the decoder consumes through slave.
interface vga_sync_decoder_if;
    logic       HSyncIn;
    logic       VSyncIn;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       display_en;
    logic       frame_start;
    logic [9:0] line_len;
    logic [9:0] frame_lines;
    logic       locked;
    logic       sync_err;

    modport master (
        output HSyncIn,
        output VSyncIn,
        input  hpos,
        input  vpos,
        input  display_en,
        input  frame_start,
        input  line_len,
        input  frame_lines,
        input  locked,
        input  sync_err
    );

    modport slave (
        input  HSyncIn,
        input  VSyncIn,
        output hpos,
        output vpos,
        output display_en,
        output frame_start,
        output line_len,
        output frame_lines,
        output locked,
        output sync_err
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// Recovers raster position from active-low HSync/VSync, measures line/frame timing, tracks lock.
// Position lags the sync inputs by 3 cycles; no backpressure, every cycle is consumed.
module vga_sync_decoder #(
    parameter int unsigned H_TOTAL      = 800,
    parameter int unsigned H_SYNC_START = 656,
    parameter int unsigned H_DISPLAY    = 640,
    parameter int unsigned V_TOTAL      = 525,
    parameter int unsigned V_SYNC_START = 513,
    parameter int unsigned V_DISPLAY    = 480,
    parameter int unsigned LOCK_FRAMES  = 2
) (
    input  logic             clk,
    input  logic             reset,
    vga_sync_decoder_if.slave bus
);

    localparam logic [9:0] HT       = 10'(H_TOTAL);
    localparam logic [9:0] HSS      = 10'(H_SYNC_START);
    localparam logic [9:0] HD       = 10'(H_DISPLAY);
    localparam logic [9:0] VT       = 10'(V_TOTAL);
    localparam logic [9:0] VSS      = 10'(V_SYNC_START);
    localparam logic [9:0] VD       = 10'(V_DISPLAY);
    localparam logic [9:0] HPER_MAX = 10'd1023;
    localparam logic [3:0] LF       = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Sync shift registers: [0]=s1, [1]=s2, [2]=s3 (history).
    logic [2:0] hs_sync;
    logic [2:0] vs_sync;

    logic [9:0] hpos;
    logic [9:0] vpos;
    logic [9:0] hper;
    logic [9:0] lcnt;
    logic [9:0] line_len;
    logic [9:0] frame_lines;
    logic       h_seen;
    logic       sync_err;
    logic       frame_start;
    logic       locked;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] good;
    logic [3:0] good_nxt;

    logic       hedge;
    logic       vedge;
    logic       hwrap;
    logic [9:0] hpos_nxt;
    logic [9:0] vpos_nxt;
    logic [9:0] hper_nxt;
    logic [9:0] lcnt_inc;
    logic [9:0] lcnt_nxt;
    logic       err_line;
    logic       err_tmo;
    logic       err_frame;
    logic       err;

    assign hedge = hs_sync[2] & ~hs_sync[1];
    assign vedge = vs_sync[2] & ~vs_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_sync <= 3'b111;
            vs_sync <= 3'b111;
        end else begin
            hs_sync <= {hs_sync[1:0], bus.HSyncIn};
            vs_sync <= {vs_sync[1:0], bus.VSyncIn};
        end
    end

    always_comb begin
        hwrap    = 1'b0;
        hpos_nxt = hpos + 10'd1;
        vpos_nxt = vpos;
        hper_nxt = hper;
        lcnt_inc = lcnt;
        lcnt_nxt = lcnt;

        if (hedge) begin
            hpos_nxt = HSS;
        end else if (hpos == HT - 10'd1) begin
            hpos_nxt = 10'd0;
            hwrap    = 1'b1;
        end

        // A VSync edge realigns vpos even if hpos wraps on the same cycle.
        if (vedge) begin
            vpos_nxt = VSS;
        end else if (hwrap) begin
            vpos_nxt = (vpos == VT - 10'd1) ? 10'd0 : vpos + 10'd1;
        end

        if (hedge) begin
            hper_nxt = 10'd1;
        end else if (hper != HPER_MAX) begin
            hper_nxt = hper + 10'd1;
        end

        // lcnt_inc already counts an HSync edge landing on the VSync edge cycle.
        lcnt_inc = lcnt + {9'd0, hedge};
        lcnt_nxt = vedge ? {9'd0, hedge} : lcnt_inc;
    end

    always_comb begin
        err_line  = hedge && h_seen && (hper != HT);
        err_tmo   = !hedge && (hper == HPER_MAX - 10'd1);
        err_frame = vedge && (lcnt_inc != VT) && (state != SEARCH);
        err       = err_line || err_tmo || err_frame;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SEARCH;
            good  <= 4'd0;
        end else begin
            state <= state_nxt;
            good  <= good_nxt;
        end
    end

    // Errors take priority over a VSync edge arriving on the same cycle.
    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        unique case (state)
            SEARCH: begin
                if (!err && vedge) begin
                    state_nxt = VERIFY;
                    good_nxt  = 4'd0;
                end
            end
            VERIFY: begin
                if (err) begin
                    state_nxt = SEARCH;
                    good_nxt  = 4'd0;
                end else if (vedge) begin
                    good_nxt = good + 4'd1;
                    if ((good + 4'd1) >= LF) begin
                        state_nxt = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (err) begin
                    state_nxt = SEARCH;
                    good_nxt  = 4'd0;
                end
            end
            default: begin
                state_nxt = SEARCH;
                good_nxt  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hpos        <= 10'd0;
            vpos        <= 10'd0;
            hper        <= 10'd0;
            lcnt        <= 10'd0;
            line_len    <= 10'd0;
            frame_lines <= 10'd0;
            h_seen      <= 1'b0;
            sync_err    <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
        end else begin
            hpos        <= hpos_nxt;
            vpos        <= vpos_nxt;
            hper        <= hper_nxt;
            lcnt        <= lcnt_nxt;
            sync_err    <= err;
            frame_start <= (hpos_nxt == 10'd0) && (vpos_nxt == 10'd0);
            locked      <= (state == LOCKED);
            if (hedge) begin
                line_len <= hper;
                h_seen   <= 1'b1;
            end
            if (vedge) begin
                frame_lines <= lcnt_inc;
            end
        end
    end

    assign bus.hpos        = hpos;
    assign bus.vpos        = vpos;
    assign bus.display_en  = (hpos < HD) && (vpos < VD);
    assign bus.frame_start = frame_start;
    assign bus.line_len    = line_len;
    assign bus.frame_lines = frame_lines;
    assign bus.locked      = locked;
    assign bus.sync_err    = sync_err;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a reduced 40x40 raster driven by a behavioural sync generator.
module tb_vga_sync_decoder;
    localparam int HT  = 40;
    localparam int HSS = 33;
    localparam int HD  = 32;
    localparam int VT  = 40;
    localparam int VSS = 37;
    localparam int VD  = 30;

    logic clk = 1'b0;
    logic reset;

    vga_sync_decoder_if bus();

    vga_sync_decoder #(
        .H_TOTAL(HT), .H_SYNC_START(HSS), .H_DISPLAY(HD),
        .V_TOTAL(VT), .V_SYNC_START(VSS), .V_DISPLAY(VD),
        .LOCK_FRAMES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int gh = 0, gv = 0, hlen = HT, vlen = VT;
    bit gen_on = 0, hs_hold = 0;
    int hfall_cyc = 0, vfall_cyc = 0, hfall_cnt = 0, vfall_cnt = 0;
    int err_cnt = 0, fs_cnt = 0, de_cnt = 0, err_cyc = 0, err_hper = 0;
    bit pos_en = 0;
    int pos_bad = 0;
    int qh[$];
    int qv[$];
    int t0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: advance the generator, drive syncs, push expected position, pop/compare the delayed one.
    task automatic tick();
        logic hs_new, vs_new;
        int eh, ev;
        @(posedge clk);
        #1;
        cyc++;
        if (gen_on) begin
            if (gh == hlen - 1) begin
                gh = 0;
                hlen = HT;
                if (gv == vlen - 1) begin
                    gv = 0;
                    vlen = VT;
                end else begin
                    gv++;
                end
            end else begin
                gh++;
            end
        end
        hs_new = hs_hold || !(gen_on && gh >= HSS && gh < HSS + 4);
        vs_new = !(gen_on && gv >= VSS && gv < VSS + 2);
        if (bus.HSyncIn && !hs_new) begin hfall_cyc = cyc; hfall_cnt++; end
        if (bus.VSyncIn && !vs_new) begin vfall_cyc = cyc; vfall_cnt++; end
        bus.HSyncIn = hs_new;
        bus.VSyncIn = vs_new;
        qh.push_back(gh);
        qv.push_back(gv);
        if (qh.size() > 3) begin
            eh = qh.pop_front();
            ev = qv.pop_front();
            if (pos_en && (bus.hpos !== 10'(eh) || bus.vpos !== 10'(ev))) pos_bad++;
        end
        if (bus.sync_err) begin err_cnt++; err_cyc = cyc; err_hper = int'(dut.hper); end
        if (bus.frame_start) fs_cnt++;
        if (bus.display_en) de_cnt++;
    endtask

    task automatic run_hfall(input int n);
        int target = hfall_cnt + n;
        int lim = 0;
        while (hfall_cnt < target && lim < 20000) begin tick(); lim++; end
        chk("hfall_wait", 32'(hfall_cnt >= target), 1);
    endtask

    task automatic run_vfall(input int n);
        int target = vfall_cnt + n;
        int lim = 0;
        while (vfall_cnt < target && lim < 20000) begin tick(); lim++; end
        chk("vfall_wait", 32'(vfall_cnt >= target), 1);
    endtask

    task automatic run_to_pos(input int tv, input int th);
        int lim = 0;
        while (!(gv == tv && gh == th) && lim < 5000) begin tick(); lim++; end
        chk("pos_wait", 32'(gv == tv && gh == th), 1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_hpos"}, bus.hpos, 0);
        chk({tag, "_vpos"}, bus.vpos, 0);
        chk({tag, "_line_len"}, bus.line_len, 0);
        chk({tag, "_frame_lines"}, bus.frame_lines, 0);
        chk({tag, "_locked"}, bus.locked, 0);
        chk({tag, "_sync_err"}, bus.sync_err, 0);
        chk({tag, "_frame_start"}, bus.frame_start, 0);
        chk({tag, "_hs_flops"}, dut.hs_sync, 3'b111);
        chk({tag, "_vs_flops"}, dut.vs_sync, 3'b111);
    endtask

    initial begin
        bus.HSyncIn = 1'b1;
        bus.VSyncIn = 1'b1;
        reset = 1'b1;
        repeat (3) tick();
        chk_reset_state("rst");
        reset = 1'b0;
        tick();
        chk("freerun_hpos1", bus.hpos, 1);
        tick();
        chk("freerun_hpos2", bus.hpos, 2);

        // Ideal raster from pixel 0 of line 0.
        gh = HT - 1;
        gv = VT - 1;
        gen_on = 1;
        err_cnt = 0;
        run_hfall(1);
        t0 = hfall_cyc;
        repeat (3) tick();
        chk("align_cycle", cyc - t0, 3);
        chk("align_hpos", bus.hpos, HSS);
        run_vfall(2);
        repeat (10) tick();
        chk("lock_not_early", bus.locked, 0);
        run_vfall(1);
        repeat (2) tick();
        chk("lock_pre_rise", bus.locked, 0);
        repeat (4) tick();
        chk("lock_rise", bus.locked, 1);
        chk("lock_no_err", err_cnt, 0);
        chk("lock_line_len", bus.line_len, HT);
        chk("lock_frame_lines", bus.frame_lines, VT);

        // One full locked frame: positions, display area, frame_start.
        pos_bad = 0;
        fs_cnt = 0;
        de_cnt = 0;
        pos_en = 1;
        repeat (HT * VT) tick();
        pos_en = 0;
        chk("pos_track", pos_bad, 0);
        chk("frame_start_count", fs_cnt, 1);
        chk("display_cycles", de_cnt, HD * VD);

        // One line stretched by a cycle while locked.
        run_to_pos(5, 0);
        hlen = HT + 1;
        err_cnt = 0;
        run_hfall(2);
        repeat (3) tick();
        chk("long_err", bus.sync_err, 1);
        chk("long_line_len", bus.line_len, HT + 1);
        chk("long_locked_at_err", bus.locked, 1);
        tick();
        chk("long_unlock", bus.locked, 0);
        run_vfall(2);
        repeat (10) tick();
        chk("long_relock_pre", bus.locked, 0);
        run_vfall(1);
        repeat (6) tick();
        chk("long_relock", bus.locked, 1);
        chk("long_err_count", err_cnt, 1);

        // HSync held high long enough for the period counter to saturate.
        run_to_pos(1, 0);
        t0 = hfall_cyc;
        err_cnt = 0;
        hs_hold = 1;
        repeat (1100) tick();
        hs_hold = 0;
        chk("stuck_err_count", err_cnt, 1);
        chk("stuck_err_hper", err_hper, 1023);
        chk("stuck_err_time", err_cyc - t0, 1025);
        chk("stuck_unlocked", bus.locked, 0);

        // Short frame while in VERIFY.
        run_vfall(2);
        repeat (5) tick();
        chk("verify_good", dut.good, 1);
        vlen = VT - 1;
        err_cnt = 0;
        run_vfall(1);
        repeat (3) tick();
        chk("short_err", bus.sync_err, 1);
        chk("short_frame_lines", bus.frame_lines, VT - 1);
        tick();
        chk("short_good_cleared", dut.good, 0);
        chk("short_locked", bus.locked, 0);
        chk("short_err_count", err_cnt, 1);

        // Reset in mid-frame while locked.
        run_vfall(3);
        repeat (6) tick();
        chk("prereset_locked", bus.locked, 1);
        run_to_pos(10, 5);
        reset = 1'b1;
        tick();
        chk_reset_state("midrst");
        reset = 1'b0;
        err_cnt = 0;
        run_vfall(2);
        repeat (10) tick();
        chk("midrst_unlocked", bus.locked, 0);
        run_vfall(1);
        repeat (6) tick();
        chk("midrst_relock", bus.locked, 1);
        chk("midrst_no_err", err_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
